rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two sources: the in-order pipeline writeback and a long-latency unit (LSU/divider) returning results out of order.
- Long-latency results are buffered in a small FIFO. A starvation counter guarantees the FIFO is drained.
- A 32-bit pending scoreboard tracks registers with outstanding long-latency writes and drives a hazard stall to ID.
- Sits between the EX/MEM/WB stages and the register file write port.

---
 rtl/rf_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline writeback competes with buffered
// long-latency results. A pending scoreboard tracks outstanding long-latency writes for the ID hazard stall.
module rf_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  output logic        pipe_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_addr_i,
  input  logic [4:0]  rs1_chk_i,
  input  logic [4:0]  rs2_chk_i,
  input  logic [4:0]  rd_chk_i,
  output logic        hazard_o,
  output logic [31:0] pending_o,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       r_fifo_addr [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [STV_W-1:0] r_starve;
  logic [STV_W-1:0] w_starve_nxt;
  logic [31:0]      r_pending;
  logic [31:0]      w_pending_nxt;
  logic             r_wren;
  logic [4:0]       r_wr_addr;
  logic [31:0]      r_wr_data;

  logic             w_nonempty;
  logic             w_full;
  logic             w_starved;
  logic             w_fifo_pri;
  logic             w_pipe_gnt;
  logic             w_enq;
  logic             w_gnt_any;
  logic [4:0]       w_head_addr;
  logic [31:0]      w_head_data;
  logic [4:0]       w_gnt_addr;
  logic [31:0]      w_gnt_data;

  // Status is decoded from registered state only, so a same-cycle dequeue never reopens a full FIFO.
  assign w_nonempty  = (r_count != '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_starved   = (r_starve == STV_W'(STARVE_LIMIT));
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  assign w_fifo_pri  = w_nonempty & (w_starved | ~pipe_valid_i);
  assign w_pipe_gnt  = ~w_fifo_pri & pipe_valid_i;
  assign w_gnt_any   = w_fifo_pri | w_pipe_gnt;
  assign w_enq       = lsu_valid_i & ~w_full;

  assign lsu_ready_o  = ~w_full;
  assign pipe_ready_o = ~(w_nonempty & w_starved);

  // NOTE: every variable in an always_comb gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_fifo_pri})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!w_nonempty || w_fifo_pri) begin
      w_starve_nxt = '0;
    end else if (w_pipe_gnt && !w_starved) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end
  end

  // Clear before set, so a re-issue in the clearing cycle leaves the bit pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_fifo_pri) begin
      w_pending_nxt[w_head_addr] = 1'b0;
    end
    if (issue_i) begin
      w_pending_nxt[issue_addr_i] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_gnt_addr = pipe_addr_i;
    w_gnt_data = pipe_data_i;
    if (w_fifo_pri) begin
      w_gnt_addr = w_head_addr;
      w_gnt_data = w_head_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_fifo_pri) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count   <= w_count_nxt;
      r_starve  <= w_starve_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // NOTE: the FIFO storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr] <= lsu_addr_i;
      r_fifo_data[r_wr_ptr] <= lsu_data_i;
    end
  end

  // Writes to x0 consume their grant but never raise the write enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wren    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wren <= w_gnt_any && (w_gnt_addr != 5'd0);
      if (w_gnt_any) begin
        r_wr_addr <= w_gnt_addr;
        r_wr_data <= w_gnt_data;
      end
    end
  end

  assign rd_wren_o = r_wren;
  assign rd_addr_o = r_wr_addr;
  assign rd_data_o = r_wr_data;
  assign pending_o = r_pending;
  assign hazard_o  = r_pending[rs1_chk_i] | r_pending[rs2_chk_i] | r_pending[rd_chk_i];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected register-file writes are queued at stimulus time.
// A negedge monitor pops one entry per observed write.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_i;
  logic        rst_ni;
  logic        pipe_valid_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        pipe_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_addr_i;
  logic [4:0]  rs1_chk_i;
  logic [4:0]  rs2_chk_i;
  logic [4:0]  rd_chk_i;
  logic        hazard_o;
  logic [31:0] pending_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int  n_checks;
  int  n_errors;
  wr_t exp_q [$];
  wr_t mon_exp;
  logic allow_reissue;

  rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pipe_valid_i (pipe_valid_i),
    .pipe_addr_i  (pipe_addr_i),
    .pipe_data_i  (pipe_data_i),
    .pipe_ready_o (pipe_ready_o),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_data_i   (lsu_data_i),
    .lsu_ready_o  (lsu_ready_o),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .rs1_chk_i    (rs1_chk_i),
    .rs2_chk_i    (rs2_chk_i),
    .rd_chk_i     (rd_chk_i),
    .hazard_o     (hazard_o),
    .pending_o    (pending_o),
    .rd_wren_o    (rd_wren_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_valid_i = 1'b1;
    pipe_addr_i  = a;
    pipe_data_i  = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_valid_i = 1'b1;
    lsu_addr_i  = a;
    lsu_data_i  = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni && rd_wren_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=0x%08h, expected no write at %0t",
                 rd_addr_o, rd_data_o, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_addr_o !== mon_exp.addr || rd_data_o !== mon_exp.data) begin
          n_errors++;
          $display("FAIL wr_order: got addr=%0d data=0x%08h, expected addr=%0d data=0x%08h at %0t",
                   rd_addr_o, rd_data_o, mon_exp.addr, mon_exp.data, $time);
        end
      end
    end
    if (rst_ni && issue_i && issue_addr_i != 5'd0) begin
      n_checks++;
      if (pending_o[issue_addr_i] && !allow_reissue) begin
        n_errors++;
        $display("FAIL illegal_issue: got issue to pending x%0d, expected issue to idle register at %0t",
                 issue_addr_i, $time);
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; allow_reissue = 1'b0;
    rst_ni = 1'b0;
    pipe_valid_i = 1'b0; pipe_addr_i = '0; pipe_data_i = '0;
    lsu_valid_i = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;
    issue_i = 1'b0; issue_addr_i = '0;
    rs1_chk_i = '0; rs2_chk_i = '0; rd_chk_i = '0;

    // Reset state
    #12;
    check("rst_wren",    {31'd0, rd_wren_o},    32'd0);
    check("rst_addr",    {27'd0, rd_addr_o},    32'd0);
    check("rst_data",    rd_data_o,             32'd0);
    check("rst_pending", pending_o,             32'd0);
    check("rst_lsu_rdy", {31'd0, lsu_ready_o},  32'd1);
    check("rst_pipe_rdy",{31'd0, pipe_ready_o}, 32'd1);
    cyc(); rst_ni = 1'b1;

    // Pipeline only, then a pipeline write to x0
    cyc(); pipe(5'd5, 32'hDEADBEEF); push(5'd5, 32'hDEADBEEF);
    #1 check("pipe_ready", {31'd0, pipe_ready_o}, 32'd1);
    cyc(); pipe(5'd0, 32'h11111111);
    check("pipe_wren",  {31'd0, rd_wren_o}, 32'd1);
    check("pipe_waddr", {27'd0, rd_addr_o}, 32'd5);
    check("pipe_wdata", rd_data_o, 32'hDEADBEEF);
    cyc(); pipe_valid_i = 1'b0;
    check("pipe_x0_wren", {31'd0, rd_wren_o}, 32'd0);

    // Starvation: one buffered result, pipeline held busy
    cyc(); lsu(5'd7, 32'h1234); pipe(5'd1, 32'h101); push(5'd1, 32'h101);
    #1 check("starve_rdy_0", {31'd0, pipe_ready_o}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      cyc(); lsu_valid_i = 1'b0; pipe(5'(i), 32'h100 + i); push(5'(i), 32'h100 + i);
      #1 check("starve_pipe_gnt", {31'd0, pipe_ready_o}, 32'd1);
    end
    cyc(); pipe(5'd6, 32'h106); push(5'd7, 32'h1234);
    #1 check("starve_backpressure", {31'd0, pipe_ready_o}, 32'd0);
    cyc(); push(5'd6, 32'h106);
    check("starve_waddr", {27'd0, rd_addr_o}, 32'd7);
    check("starve_wdata", rd_data_o, 32'h1234);
    check("starve_rdy_after", {31'd0, pipe_ready_o}, 32'd1);
    cyc(); pipe_valid_i = 1'b0;
    cyc();

    // FIFO full with the pipeline saturating
    cyc(); lsu(5'd10, 32'hB0); pipe(5'd11, 32'h211); push(5'd11, 32'h211);
    cyc(); lsu(5'd12, 32'hB1); pipe(5'd13, 32'h213); push(5'd13, 32'h213);
    #1 check("fifo_one_ready", {31'd0, lsu_ready_o}, 32'd1);
    cyc(); lsu(5'd14, 32'hB2); pipe(5'd15, 32'h215); push(5'd15, 32'h215);
    #1 check("fifo_full_ready", {31'd0, lsu_ready_o}, 32'd0);
    cyc(); pipe(5'd16, 32'h216); push(5'd16, 32'h216);
    cyc(); pipe(5'd17, 32'h217); push(5'd17, 32'h217);
    cyc(); pipe(5'd18, 32'h218); push(5'd10, 32'hB0);
    #1 check("full_starve_bp", {31'd0, pipe_ready_o}, 32'd0);
    check("full_during_deq", {31'd0, lsu_ready_o}, 32'd0);
    cyc(); push(5'd18, 32'h218);
    #1 check("full_third_accept", {31'd0, lsu_ready_o}, 32'd1);
    cyc(); pipe_valid_i = 1'b0; lsu_valid_i = 1'b0; push(5'd12, 32'hB1);
    cyc(); push(5'd14, 32'hB2);
    cyc(); cyc();

    // Scoreboard and hazard
    cyc(); issue_i = 1'b1; issue_addr_i = 5'd9;
    cyc(); issue_i = 1'b0; rs1_chk_i = 5'd9;
    check("sb_set", pending_o, 32'h0000_0200);
    #1 check("hz_rs1", {31'd0, hazard_o}, 32'd1);
    rs1_chk_i = 5'd0; rs2_chk_i = 5'd9;
    #1 check("hz_rs2", {31'd0, hazard_o}, 32'd1);
    rs2_chk_i = 5'd0; rd_chk_i = 5'd9;
    #1 check("hz_rd", {31'd0, hazard_o}, 32'd1);
    rd_chk_i = 5'd0; rs1_chk_i = 5'd8;
    #1 check("hz_none", {31'd0, hazard_o}, 32'd0);
    rs1_chk_i = 5'd9;
    cyc(); lsu(5'd9, 32'h9999); push(5'd9, 32'h9999);
    cyc(); lsu_valid_i = 1'b0;
    check("hz_hold", {31'd0, hazard_o}, 32'd1);
    cyc();
    check("sb_clr_wren", {31'd0, rd_wren_o}, 32'd1);
    check("sb_clr", pending_o, 32'd0);
    check("hz_release", {31'd0, hazard_o}, 32'd0);
    issue_i = 1'b1; issue_addr_i = 5'd9;
    cyc(); issue_i = 1'b0; lsu(5'd9, 32'h9A9A); push(5'd9, 32'h9A9A);
    cyc(); lsu_valid_i = 1'b0; allow_reissue = 1'b1; issue_i = 1'b1; issue_addr_i = 5'd9;
    cyc(); issue_i = 1'b0; allow_reissue = 1'b0;
    check("sb_setwin_wren", {31'd0, rd_wren_o}, 32'd1);
    check("sb_set_wins", pending_o, 32'h0000_0200);
    check("hz_set_wins", {31'd0, hazard_o}, 32'd1);
    lsu(5'd9, 32'h9B9B); push(5'd9, 32'h9B9B);
    cyc(); lsu_valid_i = 1'b0;
    cyc(); cyc();
    check("sb_final_clr", pending_o, 32'd0);
    rs1_chk_i = 5'd0;

    // x0 issue and simultaneous enqueue/dequeue
    cyc(); issue_i = 1'b1; issue_addr_i = 5'd3;
    cyc(); issue_addr_i = 5'd0;
    check("sb_issue3", pending_o, 32'h0000_0008);
    cyc(); issue_i = 1'b0;
    check("sb_issue_x0", pending_o, 32'h0000_0008);
    lsu(5'd20, 32'hC0); pipe(5'd21, 32'h321); push(5'd21, 32'h321);
    cyc(); pipe_valid_i = 1'b0; lsu(5'd22, 32'hC1); push(5'd20, 32'hC0);
    #1 check("simul_ready_1", {31'd0, lsu_ready_o}, 32'd1);
    cyc(); lsu(5'd0, 32'hFF); push(5'd22, 32'hC1);
    #1 check("simul_ready_2", {31'd0, lsu_ready_o}, 32'd1);
    cyc(); lsu(5'd3, 32'h333);
    cyc(); lsu_valid_i = 1'b0; push(5'd3, 32'h333);
    check("x0_lsu_wren", {31'd0, rd_wren_o}, 32'd0);
    check("x0_pending", pending_o, 32'h0000_0008);
    cyc();
    check("x3_clr", pending_o, 32'd0);
    cyc(); cyc();

    // Reset mid-operation with two buffered results
    cyc(); issue_i = 1'b1; issue_addr_i = 5'd5;
    cyc(); issue_addr_i = 5'd6;
    cyc(); issue_i = 1'b0; lsu(5'd5, 32'h55); pipe(5'd2, 32'h402); push(5'd2, 32'h402);
    cyc(); lsu(5'd6, 32'h66); pipe(5'd3, 32'h403); push(5'd3, 32'h403);
    cyc(); lsu_valid_i = 1'b0; pipe(5'd4, 32'h404);
    check("mid_full", {31'd0, lsu_ready_o}, 32'd0);
    check("mid_pending", pending_o, 32'h0000_0060);
    @(negedge clk_i); #1;
    rst_ni = 1'b0; pipe_valid_i = 1'b0;
    #1;
    check("mid_rst_wren", {31'd0, rd_wren_o}, 32'd0);
    check("mid_rst_addr", {27'd0, rd_addr_o}, 32'd0);
    check("mid_rst_data", rd_data_o, 32'd0);
    check("mid_rst_pend", pending_o, 32'd0);
    check("mid_rst_lsu_rdy", {31'd0, lsu_ready_o}, 32'd1);
    cyc(); cyc(); rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    check("post_rst_pend", pending_o, 32'd0);
    check("post_rst_lsu_rdy", {31'd0, lsu_ready_o}, 32'd1);

    // Every expected write must have been observed, within a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
